// File: rtl/uart_rx_mmio_buffer_pkg.sv
// Shared types and register offsets for the UART receive MMIO buffer.
package uart_rx_mmio_buffer_pkg;

  typedef enum logic {
    RXB_IDLE = 1'b0,
    RXB_WAIT = 1'b1
  } rxbuf_state_t;

  localparam logic [3:0] RXB_DATA_OFS = 4'h0;
  localparam logic [3:0] RXB_STAT_OFS = 4'h4;
  localparam logic [3:0] RXB_CTRL_OFS = 4'h8;

  // STATUS register layout: count in [15:8], flags in [3:0].
  function automatic logic [31:0] status_word(input logic [7:0] cnt,
                                              input logic       par,
                                              input logic       ovr,
                                              input logic       full,
                                              input logic       not_empty);
    return {16'h0, cnt, 4'h0, par, ovr, full, not_empty};
  endfunction

endpackage

// File: rtl/uart_rx_mmio_buffer_fifo.sv
// Synchronous FIFO with flush; flush overrides push and pop in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full  = (count == CNT_FULL);
  assign empty = (count == '0);
  assign dout  = mem[rd_ptr];

  // A pop on a full FIFO frees the slot the simultaneous push lands in.
  assign do_pop  = pop & ~empty & ~flush;
  assign do_push = push & (~full | do_pop) & ~flush;

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  // Storage write; contents need no reset since count gates visibility.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/uart_rx_mmio_buffer.sv
// Memory-mapped receive buffer: captures UART bytes into a FIFO and exposes
// DATA / STATUS / CTRL registers on the core's single-cycle load/store bus.
module uart_rx_mmio_buffer
  import uart_rx_mmio_buffer_pkg::*;
#(
  parameter int          DEPTH     = 16,
  parameter logic [31:0] BASE_ADDR = 32'h1000_0040
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        re,
  input  logic        we,
  input  logic [31:0] A,
  input  logic [31:0] WD,
  output logic [31:0] RD,
  input  logic        rx_done,
  input  logic [7:0]  Rx_Data,
  input  logic        parity_error,
  output logic        irq
);

  localparam int AW = $clog2(DEPTH);

  rxbuf_state_t  state;
  rxbuf_state_t  state_nxt;
  logic          push_req;

  logic [31:0]   ofs_full;
  logic [3:0]    ofs;
  logic          rd_pop;
  logic          flush;
  logic          clr_sticky;
  logic          ctrl_wr;

  logic [8:0]    fifo_dout;
  logic [AW:0]   count;
  logic [7:0]    count8;
  logic          full;
  logic          empty;

  logic          overrun;
  logic          parity_err;
  logic          irq_en;
  logic          set_ovr;
  logic          set_par;
  logic          unused_bits;

  assign ofs_full    = A - BASE_ADDR;
  assign ofs         = {ofs_full[3:2], 2'b00};
  assign unused_bits = ^{ofs_full[31:4], ofs_full[1:0], WD[31:3]};

  // Simultaneous re and we is a write, so it must not pop.
  assign rd_pop     = re & ~we & (ofs == RXB_DATA_OFS);
  assign ctrl_wr    = we & (ofs == RXB_CTRL_OFS);
  assign flush      = ctrl_wr & WD[0];
  assign clr_sticky = ctrl_wr & WD[1];
  assign count8     = 8'(count);

  // Capture FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= RXB_IDLE;
    else     state <= state_nxt;
  end

  // Capture FSM next state: one capture per rx_done level.
  always_comb begin
    state_nxt = state;
    case (state)
      RXB_IDLE: if (rx_done)  state_nxt = RXB_WAIT;
      RXB_WAIT: if (!rx_done) state_nxt = RXB_IDLE;
      default:                state_nxt = RXB_IDLE;
    endcase
  end

  // Capture FSM outputs.
  always_comb begin
    push_req = 1'b0;
    if (state == RXB_IDLE) push_req = rx_done;
  end

  sync_fifo #(.WIDTH(9), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_req),
    .pop   (rd_pop),
    .flush (flush),
    .din   ({parity_error, Rx_Data}),
    .dout  (fifo_dout),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  // A push into a full FIFO only overruns if no pop frees a slot that cycle.
  assign set_ovr = push_req & full & ~(rd_pop & ~empty) & ~flush;
  assign set_par = push_req & parity_error & ~flush;

  // Sticky flags (set beats clear), irq enable and the registered interrupt.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overrun    <= 1'b0;
      parity_err <= 1'b0;
      irq_en     <= 1'b0;
      irq        <= 1'b0;
    end else begin
      overrun    <= set_ovr | (overrun & ~clr_sticky);
      parity_err <= set_par | (parity_err & ~clr_sticky);
      if (ctrl_wr) irq_en <= WD[2];
      irq        <= ~empty & irq_en;
    end
  end

  // Combinational read mux.
  always_comb begin
    RD = 32'h0;
    case (ofs)
      RXB_DATA_OFS: if (!empty) RD = {24'h0, fifo_dout[7:0]};
      RXB_STAT_OFS: RD = status_word(count8, parity_err, overrun, full, ~empty);
      RXB_CTRL_OFS: RD = {29'h0, irq_en, 2'b00};
      default:      RD = 32'h0;
    endcase
  end

endmodule
